uart_rx_sequencer: RTL and testbench

//  Receive-side controller for the UART. Consumes the 16x oversample tick from the baud-rate generator
//  and the serial line. Runs start-detect / mid-bit sampling / framing and shifts data in LSB-first.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_sequencer_if.sv | 25 ++
 rtl/uart_sync2.sv | 28 ++
 rtl/uart_rx_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_uart_rx_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and defaults for the UART receive path
// Purpose: receive FSM state encoding and default frame geometry.
// Ports: none (package).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int UART_DEF_DATA_BITS  = 8;
  localparam int UART_DEF_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_rx_sequencer_if.sv
// rtl/uart_rx_sequencer_if.sv - received-word valid/ready handshake bundle
// Purpose: carries each received word and its status from the UART receiver to the host side.
// Signals: rx_data, rx_valid, parity_err, frame_err, overrun (master -> slave); rx_ready (slave -> master).
interface uart_rx_sequencer_if #(
  parameter int DATA_BITS = 8
) ();

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output rx_data, rx_valid, parity_err, frame_err, overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, parity_err, frame_err, overrun,
    output rx_ready
  );

endinterface

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchronizer for an asynchronous single-bit input
// Purpose: brings an asynchronous level into the clk domain.
// Ports: clk, reset_n (async active-low), d (async input), q (synchronized output).
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_sequencer.sv
// rtl/uart_rx_sequencer.sv - UART receive sequencer: start detect, mid-bit sampling, framing
// Purpose: samples the serial line on the oversample tick, assembles LSB-first words and
//          presents them with parity/framing/overrun status on a valid/ready handshake.
// Ports: clk, reset_n (async active-low), br_tick (oversample tick), rx_in (async serial line),
//        enable, parity_en, parity_odd, sample_stb (mid-bit sample pulse), busy (not idle),
//        rx_if (master side of the received-word handshake).
module uart_rx_sequencer
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DEF_DATA_BITS,
  parameter int OVERSAMPLE = UART_DEF_OVERSAMPLE
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                br_tick,
  input  logic                rx_in,
  input  logic                enable,
  input  logic                parity_en,
  input  logic                parity_odd,
  output logic                sample_stb,
  output logic                busy,
  uart_rx_sequencer_if.master rx_if
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic rx_s;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rx_in),
    .q       (rx_s)
  );

  rx_state_t            state_q, state_d;
  logic                 armed_q, armed_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 perr_q, perr_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 sample_stb_q, sample_stb_d;
  logic                 sample;
  logic                 complete;

  // Start bit is sampled half a bit in; every later bit a full bit period after the previous sample.
  assign sample = enable && br_tick && (state_q != IDLE) &&
                  (tick_q == ((state_q == START) ? TICK_MID : TICK_END));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      armed_q      <= 1'b0;
      tick_q       <= '0;
      bit_q        <= '0;
      shreg_q      <= '0;
      perr_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      sample_stb_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      tick_q       <= tick_d;
      bit_q        <= bit_d;
      shreg_q      <= shreg_d;
      perr_q       <= perr_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      sample_stb_q <= sample_stb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (armed_q && !rx_s) state_d = START;
        START:   if (sample) state_d = rx_s ? IDLE : DATA;
        DATA:    if (sample && (bit_q == LAST_BIT)) state_d = parity_en ? PARITY : STOP;
        PARITY:  if (sample) state_d = STOP;
        STOP:    if (sample) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    armed_d      = armed_q;
    tick_d       = tick_q;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    perr_d       = perr_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = overrun_q;
    sample_stb_d = sample;
    complete     = 1'b0;

    if (!enable) begin
      armed_d = 1'b0;
      tick_d  = '0;
      bit_d   = '0;
    end else begin
      if (br_tick && (state_q != IDLE) && !sample) tick_d = tick_q + TW'(1);
      case (state_q)
        IDLE: begin
          if (rx_s) armed_d = 1'b1;
          tick_d = '0;
          bit_d  = '0;
        end
        START: if (sample) begin
          tick_d = '0;
          bit_d  = '0;
        end
        DATA: if (sample) begin
          tick_d  = '0;
          shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
          bit_d   = bit_q + BW'(1);
          // Frames without a parity bit must report no parity error.
          if (bit_q == LAST_BIT) perr_d = 1'b0;
        end
        PARITY: if (sample) begin
          tick_d = '0;
          perr_d = ^shreg_q ^ rx_s ^ parity_odd;
        end
        STOP: if (sample) begin
          tick_d   = '0;
          // Held low line (break) must not re-arm until it returns high.
          armed_d  = 1'b0;
          complete = 1'b1;
        end
        default: ;
      endcase
    end

    if (complete) begin
      if (!rx_valid_q || rx_if.rx_ready) begin
        rx_data_d    = shreg_q;
        parity_err_d = perr_q;
        frame_err_d  = !rx_s;
        rx_valid_d   = 1'b1;
        if (rx_valid_q) overrun_d = 1'b0;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_if.rx_ready) begin
      rx_valid_d   = 1'b0;
      parity_err_d = 1'b0;
      frame_err_d  = 1'b0;
      overrun_d    = 1'b0;
    end
  end

  assign rx_if.rx_data    = rx_data_q;
  assign rx_if.rx_valid   = rx_valid_q;
  assign rx_if.parity_err = parity_err_q;
  assign rx_if.frame_err  = frame_err_q;
  assign rx_if.overrun    = overrun_q;
  assign sample_stb       = sample_stb_q;
  assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// tb/tb_uart_rx_sequencer.sv - self-checking bench for uart_rx_sequencer
module tb_uart_rx_sequencer;
  import uart_pkg::*;

  localparam int BIT_CLK = 64;

  logic clk = 1'b0;
  logic reset_n, br_tick, rx_in, enable, parity_en, parity_odd;
  logic sample_stb, busy;

  int checks = 0;
  int errors = 0;
  int stb_cnt = 0;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       ov;
  } word_t;

  word_t got_q[$];

  always #5 clk = ~clk;

  uart_rx_sequencer_if #(.DATA_BITS(8)) rx_if ();

  uart_rx_sequencer #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .br_tick    (br_tick),
    .rx_in      (rx_in),
    .enable     (enable),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .sample_stb (sample_stb),
    .busy       (busy),
    .rx_if      (rx_if)
  );

  initial begin
    int tdiv;
    tdiv = 0;
    br_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tdiv = tdiv + 1;
      br_tick = (tdiv % 4 == 0);
    end
  end

  // Handshake completes at the next posedge when both are seen high mid-cycle.
  always @(negedge clk) begin
    if (sample_stb === 1'b1) stb_cnt++;
    if (rx_if.rx_valid === 1'b1 && rx_if.rx_ready === 1'b1)
      got_q.push_back(word_t'{rx_if.rx_data, rx_if.parity_err, rx_if.frame_err, rx_if.overrun});
  end

  task automatic wait_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    rx_in = b;
    wait_clk(BIT_CLK);
  endtask

  // Leaves the line at the stop-bit level.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit, input logic stop);
    parity_en = pen;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (pen) send_bit(pbit);
    send_bit(stop);
  endtask

  function automatic logic exp_perr(input logic [7:0] d, input logic pen, input logic odd, input logic pbit);
    int ones;
    if (!pen) return 1'b0;
    ones = $countones(d) + (pbit ? 1 : 0);
    return ((ones % 2) == 1) != odd;
  endfunction

  task automatic test_reset;
    reset_n = 1'b0;
    rx_in = 1'b1; enable = 1'b1; parity_en = 1'b0; parity_odd = 1'b0; rx_if.rx_ready = 1'b1;
    wait_clk(3);
    checks++;
    if (rx_if.rx_valid !== 1'b0 || rx_if.rx_data !== 8'h00) begin
      errors++; $display("FAIL reset_valid_data got %b/%h exp 0/00", rx_if.rx_valid, rx_if.rx_data);
    end
    checks++;
    if ({rx_if.parity_err, rx_if.frame_err, rx_if.overrun, sample_stb, busy} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 00000",
                         {rx_if.parity_err, rx_if.frame_err, rx_if.overrun, sample_stb, busy});
    end
    reset_n = 1'b1;
    wait_clk(20);
  endtask

  task automatic test_basic;
    got_q.delete(); stb_cnt = 0;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    wait_clk(8);
    checks++;
    if (got_q.size() != 1) begin
      errors++; $display("FAIL basic_count got %0d exp 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0].d !== 8'hA5 || got_q[0].pe !== 1'b0 || got_q[0].fe !== 1'b0 || got_q[0].ov !== 1'b0) begin
        errors++; $display("FAIL basic_word got %h/%b%b%b exp a5/000", got_q[0].d, got_q[0].pe, got_q[0].fe, got_q[0].ov);
      end
    end
    checks++;
    if (stb_cnt != 10) begin
      errors++; $display("FAIL basic_stb got %0d exp 10", stb_cnt);
    end
    checks++;
    if (rx_if.rx_valid !== 1'b0) begin
      errors++; $display("FAIL basic_valid_drop got %b exp 0", rx_if.rx_valid);
    end
  endtask

  task automatic test_parity;
    parity_odd = 1'b0;
    for (int k = 0; k < 2; k++) begin
      logic pb;
      pb = (k == 0);
      got_q.delete();
      send_frame(8'h03, 1'b1, pb, 1'b1);
      wait_clk(8);
      checks++;
      if (got_q.size() != 1) begin
        errors++; $display("FAIL parity_count got %0d exp 1", got_q.size());
      end else begin
        checks++;
        if (got_q[0].d !== 8'h03 || got_q[0].pe !== pb) begin
          errors++; $display("FAIL parity_word got %h/%b exp 03/%b", got_q[0].d, got_q[0].pe, pb);
        end
      end
    end
    parity_en = 1'b0;
  endtask

  task automatic test_false_start;
    got_q.delete();
    rx_in = 1'b0;
    wait_clk(20);
    rx_in = 1'b1;
    for (int i = 0; i < 32 && busy; i++) wait_clk(1);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL false_start_busy got %b exp 0", busy);
    end
    wait_clk(40);
    checks++;
    if (got_q.size() != 0) begin
      errors++; $display("FAIL false_start_word got %0d exp 0", got_q.size());
    end
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    wait_clk(8);
    checks++;
    if (got_q.size() != 1 || got_q[0].d !== 8'h3C) begin
      errors++; $display("FAIL false_start_next got n=%0d exp n=1 data 3c", got_q.size());
    end
  endtask

  task automatic test_break;
    got_q.delete();
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    wait_clk(5 * BIT_CLK);
    checks++;
    if (got_q.size() != 1) begin
      errors++; $display("FAIL break_count got %0d exp 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0].d !== 8'h55 || got_q[0].fe !== 1'b1) begin
        errors++; $display("FAIL break_word got %h/%b exp 55/1", got_q[0].d, got_q[0].fe);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL break_busy got %b exp 0", busy);
    end
    got_q.delete();
    rx_in = 1'b1;
    wait_clk(BIT_CLK);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    wait_clk(8);
    checks++;
    if (got_q.size() != 1 || got_q[0].d !== 8'h81 || got_q[0].fe !== 1'b0) begin
      errors++; $display("FAIL break_next got n=%0d exp n=1 data 81 fe 0", got_q.size());
    end
  endtask

  task automatic test_overrun;
    got_q.delete();
    rx_if.rx_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1);
    wait_clk(8);
    checks++;
    if (rx_if.rx_valid !== 1'b1 || rx_if.rx_data !== 8'h11 || rx_if.overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_hold got v%b %h ov%b exp v1 11 ov1",
                         rx_if.rx_valid, rx_if.rx_data, rx_if.overrun);
    end
    rx_if.rx_ready = 1'b1;
    wait_clk(1);
    rx_if.rx_ready = 1'b0;
    wait_clk(1);
    checks++;
    if (rx_if.rx_valid !== 1'b0 || rx_if.overrun !== 1'b0) begin
      errors++; $display("FAIL overrun_clear got v%b ov%b exp v0 ov0", rx_if.rx_valid, rx_if.overrun);
    end
    checks++;
    if (got_q.size() != 1 || got_q[0].d !== 8'h11 || got_q[0].ov !== 1'b1) begin
      errors++; $display("FAIL overrun_word got n=%0d exp n=1 data 11 ov 1", got_q.size());
    end
    rx_if.rx_ready = 1'b1;
  endtask

  task automatic test_enable;
    rx_if.rx_ready = 1'b0;
    send_frame(8'h77, 1'b0, 1'b0, 1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    enable = 1'b0;
    wait_clk(2);
    checks++;
    if (busy !== 1'b0 || rx_if.rx_valid !== 1'b1 || rx_if.rx_data !== 8'h77) begin
      errors++; $display("FAIL enable_off got busy%b v%b %h exp busy0 v1 77", busy, rx_if.rx_valid, rx_if.rx_data);
    end
    rx_in = 1'b1;
    enable = 1'b1;
    got_q.delete();
    rx_if.rx_ready = 1'b1;
    wait_clk(BIT_CLK);
    checks++;
    if (got_q.size() != 1 || got_q[0].d !== 8'h77 || got_q[0].ov !== 1'b0) begin
      errors++; $display("FAIL enable_held got n=%0d exp n=1 data 77", got_q.size());
    end
  endtask

  task automatic test_reset_mid;
    rx_if.rx_ready = 1'b0;
    send_frame(8'h99, 1'b0, 1'b0, 1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    checks++;
    if (busy !== 1'b1 || rx_if.rx_valid !== 1'b1) begin
      errors++; $display("FAIL reset_mid_pre got busy%b v%b exp busy1 v1", busy, rx_if.rx_valid);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({rx_if.rx_valid, rx_if.overrun, busy, rx_if.rx_data} !== 11'b0) begin
      errors++; $display("FAIL reset_mid_outputs got v%b ov%b busy%b %h exp all 0",
                         rx_if.rx_valid, rx_if.overrun, busy, rx_if.rx_data);
    end
    rx_in = 1'b1;
    wait_clk(2);
    reset_n = 1'b1;
    rx_if.rx_ready = 1'b1;
    wait_clk(BIT_CLK);
    got_q.delete();
    send_frame(8'hF0, 1'b0, 1'b0, 1'b1);
    wait_clk(8);
    checks++;
    if (got_q.size() != 1 || got_q[0].d !== 8'hF0 || got_q[0].pe !== 1'b0 || got_q[0].fe !== 1'b0) begin
      errors++; $display("FAIL reset_mid_next got n=%0d exp n=1 data f0 no errors", got_q.size());
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 16; n++) begin
      logic [7:0] d;
      logic pen, odd, pbit, stop, epe;
      d    = 8'($urandom);
      pen  = 1'($urandom);
      odd  = 1'($urandom);
      pbit = 1'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      epe  = exp_perr(d, pen, odd, pbit);
      parity_odd = odd;
      got_q.delete();
      send_frame(d, pen, pbit, stop);
      rx_in = 1'b1;
      wait_clk(40);
      checks++;
      if (got_q.size() != 1) begin
        errors++; $display("FAIL random_count frame %0d got %0d exp 1", n, got_q.size());
      end else if (got_q[0].d !== d || got_q[0].pe !== epe || got_q[0].fe !== !stop || got_q[0].ov !== 1'b0) begin
        errors++; $display("FAIL random_word frame %0d got %h/%b%b exp %h/%b%b",
                           n, got_q[0].d, got_q[0].pe, got_q[0].fe, d, epe, !stop);
      end
    end
    parity_en = 1'b0;
    parity_odd = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_false_start();
    test_break();
    test_overrun();
    test_enable();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
